// File: rtl/logic_operand_loader_pkg.sv
// Shared definitions for the logic operand loader and the logic engine it feeds:
// header field constants, engine opcodes, loader FSM states, header checker.
package logic_operand_loader_pkg;

    // Header layout: [7:6] marker, [5:2] reserved (must be zero), [1:0] opcode
    localparam logic [1:0] HDR_MARKER    = 2'b10;
    localparam logic [7:0] HDR_RSVD_MASK = 8'h3C;

    // Opcodes understood by the combinational logic engine
    localparam logic [1:0] OP_OR   = 2'd0;
    localparam logic [1:0] OP_NAND = 2'd1;
    localparam logic [1:0] OP_NOR  = 2'd2;
    localparam logic [1:0] OP_AND  = 2'd3;

    // Loader assembly states: waiting for header, operand A, operand B
    typedef enum logic [1:0] {
        HDR   = 2'd0,
        GET_A = 2'd1,
        GET_B = 2'd2
    } state_t;

    // A header is well formed when the marker matches and no reserved bit is set
    function automatic logic is_valid_header(input logic [7:0] hdr);
        return (hdr[7:6] == HDR_MARKER) && ((hdr & HDR_RSVD_MASK) == 8'h00);
    endfunction

endpackage

// File: rtl/logic_out_slot.sv
// Single-entry output register between the loader and the logic engine.
// Holds its word while the engine stalls; a new load may coincide with the
// draining handshake so the slot never has to go empty between words.
module logic_out_slot
    import logic_operand_loader_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OPC_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [OPC_W-1:0]  load_opcode,
    input  logic [DATA_W-1:0] load_a,
    input  logic [DATA_W-1:0] load_b,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [OPC_W-1:0]  out_opcode,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b
);

    // Load wins over drain so a same-cycle handshake and refill keep valid high
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_opcode <= OPC_W'(OP_OR);
            out_a      <= '0;
            out_b      <= '0;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_opcode <= load_opcode;
            out_a      <= load_a;
            out_b      <= load_b;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/logic_operand_loader.sv
// Assembles 3-byte instructions (header, A, B) from a byte stream and hands
// {opcode, A, B} to the logic engine through a registered output slot.
// Malformed headers are dropped with a one-cycle error pulse.
module logic_operand_loader
    import logic_operand_loader_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OPC_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OPC_W-1:0]  out_opcode,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  issued_count,
    output logic              busy
);

    state_t            state;
    logic [OPC_W-1:0]  opc_latch;
    logic [DATA_W-1:0] a_latch;
    logic              byte_accept;
    logic              out_fire;
    logic              hdr_ok;
    logic              slot_load;

    // Operand B may only be taken when the output slot is free or draining now
    assign in_ready    = (state != GET_B) || !out_valid || out_ready;
    assign byte_accept = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;
    assign hdr_ok      = is_valid_header(in_byte[7:0]);
    assign slot_load   = byte_accept && (state == GET_B);
    assign busy        = (state != HDR) || out_valid;

    // Assembly FSM; a rejected header leaves both state and latched opcode alone
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HDR;
            opc_latch <= '0;
            a_latch   <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (byte_accept) begin
                case (state)
                    HDR: begin
                        if (hdr_ok) begin
                            opc_latch <= in_byte[OPC_W-1:0];
                            state     <= GET_A;
                        end else begin
                            err_pulse <= 1'b1;
                        end
                    end
                    GET_A: begin
                        a_latch <= in_byte;
                        state   <= GET_B;
                    end
                    GET_B: begin
                        state <= HDR;
                    end
                    default: begin
                        state <= HDR;
                    end
                endcase
            end
        end
    end

    // Count completed output handshakes, wrapping at the counter width
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_count <= '0;
        end else if (out_fire) begin
            issued_count <= issued_count + 1'b1;
        end
    end

    logic_out_slot #(
        .DATA_W (DATA_W),
        .OPC_W  (OPC_W)
    ) u_slot (
        .clk         (clk),
        .rst         (rst),
        .load        (slot_load),
        .load_opcode (opc_latch),
        .load_a      (a_latch),
        .load_b      (in_byte),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_opcode  (out_opcode),
        .out_a       (out_a),
        .out_b       (out_b)
    );

endmodule

// File: tb/tb_logic_operand_loader.sv
// Directed testbench for logic_operand_loader; counter narrowed to 4 bits so
// the wrap can be reached with a short stream.
module tb_logic_operand_loader;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_opcode;
    logic [7:0] out_a;
    logic [7:0] out_b;
    logic       err_pulse;
    logic [3:0] issued_count;
    logic       busy;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    logic [3:0] exp_cnt;

    logic_operand_loader #(
        .DATA_W (8),
        .OPC_W  (2),
        .CNT_W  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_byte      (in_byte),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_opcode   (out_opcode),
        .out_a        (out_a),
        .out_b        (out_b),
        .err_pulse    (err_pulse),
        .issued_count (issued_count),
        .busy         (busy)
    );

    // Free-running clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until it is taken (bounded wait)
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_byte  = b;
        #1;
        while (!in_ready && waited < 20) begin
            step();
            waited++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL send_timeout byte=%h in_ready=%b required=1", b, in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_word(input string name, input logic [1:0] opc,
                              input logic [7:0] a, input logic [7:0] b);
        vectors++;
        if (out_valid !== 1'b1 || out_opcode !== opc || out_a !== a || out_b !== b) begin
            miscompares++;
            $display("[TB] FAIL %s got v=%b op=%0d a=%h b=%h required v=1 op=%0d a=%h b=%h",
                     name, out_valid, out_opcode, out_a, out_b, opc, a, b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b1;
        step(); step();
        vectors++;
        if (out_valid !== 1'b0 || out_opcode !== 2'd0 || out_a !== 8'h00 || out_b !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs got v=%b op=%0d a=%h b=%h required all 0",
                     out_valid, out_opcode, out_a, out_b);
        end
        vectors++;
        if (err_pulse !== 1'b0 || issued_count !== 4'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_status got err=%b cnt=%0d busy=%b required 0 0 0",
                     err_pulse, issued_count, busy);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_in_ready got %b required 1", in_ready);
        end
        exp_cnt = 4'd0;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_byte(8'h83); send_byte(8'hF0); send_byte(8'h3C);
        check_word("basic_word", 2'd3, 8'hF0, 8'h3C);
        vectors++;
        if (issued_count !== exp_cnt) begin
            miscompares++;
            $display("[TB] FAIL basic_cnt_before got %0d required %0d", issued_count, exp_cnt);
        end
        step();
        exp_cnt++;
        vectors++;
        if (issued_count !== exp_cnt || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_cnt_after got cnt=%0d v=%b required cnt=%0d v=0",
                     issued_count, out_valid, exp_cnt);
        end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        send_byte(8'h80); send_byte(8'h11); send_byte(8'h22);
        check_word("bp_first", 2'd0, 8'h11, 8'h22);
        send_byte(8'h81); send_byte(8'h33);
        check_word("bp_first_held", 2'd0, 8'h11, 8'h22);
        in_valid = 1'b1; in_byte = 8'h44;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_in_ready_low got %b required 0", in_ready);
        end
        step(); step();
        check_word("bp_still_held", 2'd0, 8'h11, 8'h22);
        vectors++;
        if (in_ready !== 1'b0 || issued_count !== exp_cnt) begin
            miscompares++;
            $display("[TB] FAIL bp_stalled got rdy=%b cnt=%0d required rdy=0 cnt=%0d",
                     in_ready, issued_count, exp_cnt);
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_in_ready_release got %b required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        exp_cnt++;
        check_word("bp_second", 2'd1, 8'h33, 8'h44);
        vectors++;
        if (issued_count !== exp_cnt) begin
            miscompares++;
            $display("[TB] FAIL bp_cnt_simul got %0d required %0d", issued_count, exp_cnt);
        end
        step();
        exp_cnt++;
        vectors++;
        if (issued_count !== exp_cnt || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_drain got cnt=%0d v=%b required cnt=%0d v=0",
                     issued_count, out_valid, exp_cnt);
        end
    endtask

    task automatic test_bad_header();
        out_ready = 1'b1;
        send_byte(8'h43);
        vectors++;
        if (err_pulse !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bad_hdr_err got err=%b busy=%b required err=1 busy=0", err_pulse, busy);
        end
        send_byte(8'h82);
        vectors++;
        if (err_pulse !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bad_hdr_one_cycle got err=%b required 0", err_pulse);
        end
        send_byte(8'h0F); send_byte(8'hF0);
        check_word("bad_hdr_word", 2'd2, 8'h0F, 8'hF0);
        step();
        exp_cnt++;
        send_byte(8'h84);
        vectors++;
        if (err_pulse !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rsvd_hdr_err got err=%b required 1", err_pulse);
        end
        step();
        vectors++;
        if (err_pulse !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rsvd_hdr_after got err=%b busy=%b required 0 0", err_pulse, busy);
        end
        send_byte(8'h81); send_byte(8'h77); send_byte(8'h88);
        check_word("rsvd_hdr_next_word", 2'd1, 8'h77, 8'h88);
        step();
        exp_cnt++;
        vectors++;
        if (issued_count !== exp_cnt) begin
            miscompares++;
            $display("[TB] FAIL bad_hdr_cnt got %0d required %0d", issued_count, exp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send_byte(8'h83); send_byte(8'h55); send_byte(8'h66);
        send_byte(8'h80); send_byte(8'hAA);
        rst = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b0 || out_opcode !== 2'd0 || out_a !== 8'h00 || out_b !== 8'h00 ||
            issued_count !== 4'd0 || err_pulse !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_outputs got v=%b op=%0d a=%h b=%h cnt=%0d err=%b busy=%b required all 0",
                     out_valid, out_opcode, out_a, out_b, issued_count, err_pulse, busy);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        exp_cnt = 4'd0;
        send_byte(8'h81); send_byte(8'h01); send_byte(8'h02);
        check_word("mid_reset_word", 2'd1, 8'h01, 8'h02);
        step();
        exp_cnt++;
        vectors++;
        if (issued_count !== exp_cnt) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_cnt got %0d required %0d", issued_count, exp_cnt);
        end
    endtask

    task automatic test_throughput_wrap();
        int first_cyc;
        int last_cyc;
        logic [7:0] a;
        logic [1:0] op;
        first_cyc = 0;
        last_cyc  = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            op = 2'(k % 4);
            a  = 8'(k * 17 + 3);
            send_byte({6'b100000, op});
            send_byte(a);
            if (k > 0) begin
                vectors++;
                if (out_valid !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL tp_gap_%0d got v=%b required 0", k, out_valid);
                end
            end
            send_byte(~a);
            if (k == 0) first_cyc = cyc;
            last_cyc = cyc;
            check_word("tp_word", op, a, ~a);
            vectors++;
            if (issued_count !== exp_cnt) begin
                miscompares++;
                $display("[TB] FAIL tp_cnt_%0d got %0d required %0d", k, issued_count, exp_cnt);
            end
            exp_cnt++;
        end
        step();
        vectors++;
        if (issued_count !== exp_cnt || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL tp_wrap_final got cnt=%0d v=%b required cnt=%0d v=0",
                     issued_count, out_valid, exp_cnt);
        end
        vectors++;
        if (last_cyc - first_cyc !== 45) begin
            miscompares++;
            $display("[TB] FAIL tp_rate got %0d cycles required 45", last_cyc - first_cyc);
        end
    endtask

    task automatic test_input_gaps();
        logic [7:0] hdr_t [5] = '{8'h80, 8'h83, 8'h82, 8'h81, 8'h83};
        logic [7:0] a_t   [5] = '{8'hDE, 8'h01, 8'h7F, 8'hC3, 8'h5A};
        logic [7:0] b_t   [5] = '{8'hAD, 8'hFE, 8'h80, 8'h3C, 8'hA5};
        logic [7:0] seq   [3];
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            seq[0] = hdr_t[i]; seq[1] = a_t[i]; seq[2] = b_t[i];
            for (int j = 0; j < 3; j++) begin
                int gap;
                gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    in_byte  = 8'($urandom);
                    step();
                end
                send_byte(seq[j]);
            end
            check_word("gap_word", hdr_t[i][1:0], a_t[i], b_t[i]);
            vectors++;
            if (issued_count !== exp_cnt) begin
                miscompares++;
                $display("[TB] FAIL gap_cnt_%0d got %0d required %0d", i, issued_count, exp_cnt);
            end
            exp_cnt++;
        end
        step();
        vectors++;
        if (issued_count !== exp_cnt || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL gap_final got cnt=%0d busy=%b required cnt=%0d busy=0",
                     issued_count, busy, exp_cnt);
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b0;
        exp_cnt = 4'd0;
        test_reset();
        test_basic();
        test_back_pressure();
        test_bad_header();
        test_reset_mid();
        test_throughput_wrap();
        test_input_gaps();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
